// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//   I2S transmitter for a CS4344-class stereo DAC. A single free-running
//   frame counter produces mclk/sck/lrck as direct register bits. Once per
//   frame (counter wrap) the left/right samples are captured, or zero when
//   muted. They are then shifted out MSB-first on sdin with the standard
//   I2S one-bit delay after each lrck edge.
//
// Ports
//   clk          in   system clock (100 MHz)
//   rst_n        in   asynchronous active-low reset
//   audio_left   in   signed left sample, two's complement
//   audio_right  in   signed right sample, two's complement
//   mute         in   level; zero samples are captured while high
//   mclk         out  DAC master clock, clk/4
//   sck          out  serial bit clock, clk/16
//   lrck         out  word select, clk/512 (0 = left, 1 = right)
//   sdin         out  serial data, changes on sck falling edges
//   sample_tick  out  one-clk pulse on the cycle samples were captured
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdin,
    output logic                sample_tick
);

    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] left_d;
    logic [SAMPLE_W-1:0] right_q;
    logic [SAMPLE_W-1:0] right_d;
    logic                sdin_q;
    logic                sdin_d;
    logic                tick_q;
    logic                tick_d;

    logic                frame_end_s;
    logic                slot_end_s;
    logic                ch_next_s;
    logic [3:0]          slot_next_s;
    logic [3:0]          bit_idx_s;
    logic [SAMPLE_W-1:0] word_s;

    // Next-state logic: counter, frame capture and serial bit selection.
    always_comb begin
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        frame_end_s = (cnt_q == {CNT_W{1'b1}});
        slot_end_s  = (cnt_q[3:0] == 4'hF);

        // Channel/slot that begins on the coming edge.
        ch_next_s   = cnt_d[8];
        slot_next_s = cnt_d[7:4];

        left_d  = left_q;
        right_d = right_q;
        tick_d  = frame_end_s;
        if (frame_end_s) begin
            if (mute) begin
                left_d  = {SAMPLE_W{1'b0}};
                right_d = {SAMPLE_W{1'b0}};
            end else begin
                left_d  = audio_left;
                right_d = audio_right;
            end
        end else begin
            left_d  = left_q;
            right_d = right_q;
        end

        // Slot s carries bit (16-s); modulo 16 that is simply -s.
        word_s    = ch_next_s ? right_q : left_q;
        bit_idx_s = 4'd0 - slot_next_s;

        sdin_d = sdin_q;
        if (slot_end_s) begin
            if (slot_next_s == 4'd0) begin
                // Slot 0 carries the LSB of the word that just ended. On the
                // frame wrap right_q still holds the previous frame's word
                // (capture happens on this same edge), so it doubles as the
                // held right LSB without a separate register.
                if (ch_next_s) begin
                    sdin_d = left_q[0];
                end else begin
                    sdin_d = right_q[0];
                end
            end else begin
                sdin_d = word_s[bit_idx_s];
            end
        end else begin
            sdin_d = sdin_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            left_q  <= {SAMPLE_W{1'b0}};
            right_q <= {SAMPLE_W{1'b0}};
            sdin_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            sdin_q  <= sdin_d;
            tick_q  <= tick_d;
        end
    end

    // Outputs are straight register bits.
    assign mclk        = cnt_q[1];
    assign sck         = cnt_q[3];
    assign lrck        = cnt_q[8];
    assign sdin        = sdin_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_left = 16'h0;
    logic [15:0] audio_right = 16'h0;
    logic        mute = 1'b0;
    logic        mclk, sck, lrck, sdin, sample_tick;

    int total = 0;
    int bad = 0;

    audio_i2s_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .mute        (mute),
        .mclk        (mclk),
        .sck         (sck),
        .lrck        (lrck),
        .sdin        (sdin),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    // Bench I2S receiver: sample on sck rise; the bit after an lrck change
    // is the LSB of the word for the previous channel.
    logic [15:0] dec_sh = 16'h0;
    logic [15:0] dec_left = 16'h0;
    logic [15:0] dec_right = 16'h0;
    logic        dec_prev_l = 1'b0;
    logic        dec_l0_bit = 1'b0;

    always @(posedge sck) begin
        if (lrck != dec_prev_l) begin
            if (dec_prev_l) begin
                dec_right  <= {dec_sh[14:0], sdin};
                dec_l0_bit <= sdin;
            end else begin
                dec_left <= {dec_sh[14:0], sdin};
            end
            dec_sh <= 16'h0;
        end else begin
            dec_sh <= {dec_sh[14:0], sdin};
        end
        dec_prev_l <= lrck;
    end

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_tick: got no sample_tick within 600 clk, required one");
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int   tick_at;
        logic sdin_or;
        audio_left  = 16'h1111;
        audio_right = 16'h2222;
        rst_n = 1'b0;
        wait_cycles(5);
        total++;
        if ({mclk, sck, lrck, sdin, sample_tick} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 00000", {mclk, sck, lrck, sdin, sample_tick});
        end
        rst_n = 1'b1;
        tick_at = -1;
        sdin_or = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                tick_at = i;
                break;
            end
            sdin_or = sdin_or | sdin;
        end
        total++;
        if (tick_at !== 512) begin
            bad++;
            $display("FAIL reset_first_tick: got %0d clk required 512", tick_at);
        end
        total++;
        if (sdin_or !== 1'b0) begin
            bad++;
            $display("FAIL reset_frame0_zero: got sdin activity %b required 0", sdin_or);
        end
    endtask

    task automatic test_clock_ratios();
        logic [3:0] cur, prv;
        int last[4];
        int pmin[4];
        int pmax[4];
        int exp_p[4];
        int lr_edges, aligned;
        exp_p[0] = 4; exp_p[1] = 16; exp_p[2] = 512; exp_p[3] = 512;
        for (int j = 0; j < 4; j++) begin
            last[j] = -1; pmin[j] = 100000; pmax[j] = 0;
        end
        lr_edges = 0;
        aligned = 0;
        @(negedge clk);
        prv = {sample_tick, lrck, sck, mclk};
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            cur = {sample_tick, lrck, sck, mclk};
            for (int j = 0; j < 4; j++) begin
                if (cur[j] && !prv[j]) begin
                    if (last[j] >= 0) begin
                        if (i - last[j] < pmin[j]) pmin[j] = i - last[j];
                        if (i - last[j] > pmax[j]) pmax[j] = i - last[j];
                    end
                    last[j] = i;
                end
            end
            if (cur[2] != prv[2]) begin
                lr_edges++;
                if (prv[1] && !cur[1]) aligned++;
            end
            prv = cur;
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (pmin[j] !== exp_p[j] || pmax[j] !== exp_p[j]) begin
                bad++;
                $display("FAIL period_%0d: got min=%0d max=%0d required %0d", j, pmin[j], pmax[j], exp_p[j]);
            end
        end
        total++;
        if (lr_edges !== 8) begin
            bad++;
            $display("FAIL lrck_edges: got %0d required 8", lr_edges);
        end
        total++;
        if (aligned !== 8) begin
            bad++;
            $display("FAIL lrck_sck_align: got %0d aligned required 8", aligned);
        end
    endtask

    task automatic test_data(input logic [15:0] l, input logic [15:0] r, input string name);
        audio_left  = l;
        audio_right = r;
        wait_tick();
        wait_tick();
        wait_cycles(16);
        total++;
        if (dec_left !== l) begin
            bad++;
            $display("FAIL %s_left: got %h required %h", name, dec_left, l);
        end
        total++;
        if (dec_right !== r) begin
            bad++;
            $display("FAIL %s_right: got %h required %h", name, dec_right, r);
        end
        total++;
        if (dec_l0_bit !== r[0]) begin
            bad++;
            $display("FAIL %s_slot0: got %b required %b", name, dec_l0_bit, r[0]);
        end
    endtask

    task automatic test_mute();
        audio_left  = 16'h1234;
        audio_right = 16'h5678;
        wait_tick();
        wait_cycles(200);
        mute = 1'b1;
        wait_tick();
        wait_cycles(16);
        total++;
        if ({dec_left, dec_right} !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mute_current_frame: got %h required 12345678", {dec_left, dec_right});
        end
        wait_tick();
        wait_cycles(16);
        total++;
        if ({dec_left, dec_right} !== 32'h0) begin
            bad++;
            $display("FAIL mute_next_frame: got %h required 00000000", {dec_left, dec_right});
        end
        mute = 1'b0;
    endtask

    task automatic test_mid_change();
        audio_left  = 16'h1234;
        audio_right = 16'h5678;
        wait_tick();
        wait_cycles(300);
        audio_left  = 16'hBEEF;
        audio_right = 16'h0F0F;
        wait_tick();
        wait_cycles(16);
        total++;
        if ({dec_left, dec_right} !== 32'h1234_5678) begin
            bad++;
            $display("FAIL midchange_current: got %h required 12345678", {dec_left, dec_right});
        end
        wait_tick();
        wait_cycles(16);
        total++;
        if ({dec_left, dec_right} !== 32'hBEEF_0F0F) begin
            bad++;
            $display("FAIL midchange_next: got %h required beef0f0f", {dec_left, dec_right});
        end
    endtask

    task automatic test_reset_mid();
        int   tick_at;
        logic sdin_or;
        audio_left  = 16'h1357;
        audio_right = 16'h2468;
        wait_tick();
        wait_cycles(290);
        rst_n = 1'b0;
        #1;
        total++;
        if ({mclk, sck, lrck, sdin, sample_tick} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_async: got %b required 00000", {mclk, sck, lrck, sdin, sample_tick});
        end
        wait_cycles(3);
        rst_n = 1'b1;
        tick_at = -1;
        sdin_or = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                tick_at = i;
                break;
            end
            sdin_or = sdin_or | sdin;
        end
        total++;
        if (tick_at !== 512) begin
            bad++;
            $display("FAIL midreset_restart: got %0d clk required 512", tick_at);
        end
        total++;
        if (sdin_or !== 1'b0) begin
            bad++;
            $display("FAIL midreset_zero_frame: got sdin activity %b required 0", sdin_or);
        end
        wait_tick();
        wait_cycles(16);
        total++;
        if ({dec_left, dec_right} !== 32'h1357_2468) begin
            bad++;
            $display("FAIL midreset_recover: got %h required 13572468", {dec_left, dec_right});
        end
    endtask

    initial begin
        test_reset();
        test_clock_ratios();
        test_data(16'hA5C3, 16'h0080, "data");
        test_data(16'hFC00, 16'h7FFF, "negfs");
        test_data(16'h8000, 16'h8000, "minfs");
        test_mute();
        test_mid_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
